// File: rtl/cache_ctrl.sv
// Direct-mapped read-only cache controller: zero-cycle hits, word-by-word
// line refill from memory, and a sweeping invalidate-all flush.
module cache_ctrl #(
    parameter int BLKIDX_BIT = 4,
    parameter int OFFSET_BIT = 2,
    parameter int TAG_BIT    = 32 - BLKIDX_BIT - OFFSET_BIT - 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cpu_req,
    input  logic [31:0]                      cpu_addr,
    input  logic                             flush,
    output logic                             cpu_ready,
    output logic [31:0]                      cpu_rdata,
    output logic                             busy,
    output logic [BLKIDX_BIT-1:0]            blkidx,
    output logic                             valid_wen,
    output logic                             valid_wdata,
    input  logic                             valid_rdata,
    output logic                             tag_wen,
    output logic [TAG_BIT-1:0]               tag_wdata,
    input  logic [TAG_BIT-1:0]               tag_rdata,
    output logic [BLKIDX_BIT+OFFSET_BIT-1:0] data_idx,
    output logic                             data_wen,
    output logic [31:0]                      data_wdata,
    input  logic [31:0]                      data_rdata,
    output logic                             mem_req,
    output logic [31:0]                      mem_addr,
    input  logic                             mem_ack,
    input  logic [31:0]                      mem_rdata
);

    localparam int IDX_LSB = OFFSET_BIT + 2;
    localparam int TAG_LSB = BLKIDX_BIT + OFFSET_BIT + 2;

    typedef enum logic [1:0] {
        LOOKUP,
        REFILL,
        FLUSH
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [TAG_BIT-1:0]      r_tag;
    logic [BLKIDX_BIT-1:0]   r_idx;
    logic [OFFSET_BIT-1:0]   r_cnt;
    logic [BLKIDX_BIT-1:0]   r_fcnt;
    logic                    r_pend;

    logic [TAG_BIT-1:0]      w_tag;
    logic [BLKIDX_BIT-1:0]   w_idx;
    logic [OFFSET_BIT-1:0]   w_off;
    logic                    w_hit;
    logic                    w_miss;
    logic                    w_unused;

    assign w_tag    = cpu_addr[31:TAG_LSB];
    assign w_idx    = cpu_addr[TAG_LSB-1:IDX_LSB];
    assign w_off    = cpu_addr[IDX_LSB-1:2];
    assign w_unused = ^cpu_addr[1:0];

    assign w_hit = cpu_req & valid_rdata & (tag_rdata == w_tag);

    // Refill datapath always reflects the latched line and word counter
    assign mem_addr   = {r_tag, r_idx, r_cnt, 2'b00};
    assign tag_wdata  = r_tag;
    assign data_wdata = mem_rdata;
    assign cpu_rdata  = data_rdata;

    // Next-state decode and per-state array/memory strobes
    always_comb begin
        w_state_nxt = r_state;
        w_miss      = 1'b0;
        cpu_ready   = 1'b0;
        busy        = 1'b0;
        blkidx      = w_idx;
        data_idx    = {w_idx, w_off};
        valid_wen   = 1'b0;
        valid_wdata = 1'b0;
        tag_wen     = 1'b0;
        data_wen    = 1'b0;
        mem_req     = 1'b0;
        unique case (r_state)
            LOOKUP: begin
                if (flush) begin
                    w_state_nxt = FLUSH;
                end else if (w_hit) begin
                    cpu_ready = 1'b1;
                end else if (cpu_req) begin
                    w_miss      = 1'b1;
                    w_state_nxt = REFILL;
                end
            end
            REFILL: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                blkidx   = r_idx;
                data_idx = {r_idx, r_cnt};
                if (mem_ack) begin
                    data_wen = 1'b1;
                    if (&r_cnt) begin
                        tag_wen     = 1'b1;
                        valid_wen   = 1'b1;
                        valid_wdata = 1'b1;
                        w_state_nxt = (r_pend | flush) ? FLUSH : LOOKUP;
                    end
                end
            end
            FLUSH: begin
                busy      = 1'b1;
                blkidx    = r_fcnt;
                valid_wen = 1'b1;
                if (&r_fcnt) begin
                    w_state_nxt = LOOKUP;
                end
            end
            default: begin
                w_state_nxt = LOOKUP;
            end
        endcase
        if (rst) begin
            w_state_nxt = LOOKUP;
            w_miss      = 1'b0;
            cpu_ready   = 1'b0;
            busy        = 1'b0;
            valid_wen   = 1'b0;
            tag_wen     = 1'b0;
            data_wen    = 1'b0;
            mem_req     = 1'b0;
        end
    end

    // State, latched miss address, word/flush counters and pending flush
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOOKUP;
            r_tag   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_fcnt  <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_miss) begin
                r_tag <= w_tag;
                r_idx <= w_idx;
                r_cnt <= '0;
            end else if (r_state == REFILL && mem_ack) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state != FLUSH && w_state_nxt == FLUSH) begin
                r_fcnt <= '0;
            end else if (r_state == FLUSH) begin
                r_fcnt <= r_fcnt + 1'b1;
            end
            if (r_state == REFILL) begin
                if (w_state_nxt != REFILL) begin
                    r_pend <= 1'b0;
                end else if (flush) begin
                    r_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with behavioural valid/tag/data arrays
// and a bench-driven memory returning a fixed function of the address.
module tb_cache_ctrl;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        flush;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        busy;
    logic [3:0]  blkidx;
    logic        valid_wen;
    logic        valid_wdata;
    logic        valid_rdata;
    logic        tag_wen;
    logic [23:0] tag_wdata;
    logic [23:0] tag_rdata;
    logic [5:0]  data_idx;
    logic        data_wen;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic        v_arr [16];
    logic [23:0] t_arr [16];
    logic [31:0] d_arr [64];

    cache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .flush(flush),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .busy(busy),
        .blkidx(blkidx),
        .valid_wen(valid_wen), .valid_wdata(valid_wdata),
        .valid_rdata(valid_rdata),
        .tag_wen(tag_wen), .tag_wdata(tag_wdata), .tag_rdata(tag_rdata),
        .data_idx(data_idx), .data_wen(data_wen),
        .data_wdata(data_wdata), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign valid_rdata = v_arr[blkidx];
    assign tag_rdata   = t_arr[blkidx];
    assign data_rdata  = d_arr[data_idx];

    // Array storage; the valid array clears itself on reset
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) v_arr[i] <= 1'b0;
        end else if (valid_wen) begin
            v_arr[blkidx] <= valid_wdata;
        end
        if (tag_wen) t_arr[blkidx] <= tag_wdata;
        if (data_wen) d_arr[data_idx] <= data_wdata;
    end

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_0000;
    endfunction

    // Lookup miss on addr, full refill, then the cycle after the last ack
    task automatic do_miss(input logic [31:0] addr, input bit fl_in);
        logic [31:0] base;
        logic [1:0]  kk;
        logic [2:0]  wexp;
        base = addr & 32'hFFFF_FFF0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = addr; flush = 1'b0; mem_ack = 1'b0;
        #1;
        n_checks++;
        if ({cpu_ready, busy, mem_req} !== 3'b000) begin
            n_errors++;
            $display("FAIL miss_lookup %h: rdy/busy/mreq=%b want 000",
                     addr, {cpu_ready, busy, mem_req});
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({busy, mem_req, data_wen, cpu_ready} !== 4'b1100 ||
            mem_addr !== base) begin
            n_errors++;
            $display("FAIL refill_start %h: b/mr/dw/rdy=%b addr=%h want 1100 %h",
                     addr, {busy, mem_req, data_wen, cpu_ready},
                     mem_addr, base);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            kk = k[1:0];
            mem_ack   = 1'b1;
            mem_rdata = memw(base + 32'(4 * k));
            flush     = fl_in && (k == 0);
            cpu_addr  = 32'h0000_0880 + 32'(k * 4);
            cpu_req   = kk[0];
            #1;
            wexp = (k == 3) ? 3'b111 : 3'b000;
            n_checks++;
            if (mem_addr !== base + 32'(4 * k) || data_wen !== 1'b1 ||
                data_idx !== {base[7:4], kk} || cpu_ready !== 1'b0 ||
                {tag_wen, valid_wen, valid_wdata} !== wexp ||
                (k == 3 && tag_wdata !== base[31:8])) begin
                n_errors++;
                $display("FAIL ack%0d %h: maddr=%h dw=%b didx=%h rdy=%b tvv=%b tag=%h want %h 1 %h 0 %b %h",
                         k, addr, mem_addr, data_wen, data_idx, cpu_ready,
                         {tag_wen, valid_wen, valid_wdata}, tag_wdata,
                         base + 32'(4 * k), {base[7:4], kk}, wexp,
                         base[31:8]);
            end
        end
        @(negedge clk);
        mem_ack = 1'b0; flush = 1'b0; cpu_req = 1'b1; cpu_addr = addr;
        #1;
        n_checks++;
        if (!fl_in) begin
            if (cpu_ready !== 1'b1 || cpu_rdata !== memw(addr) ||
                busy !== 1'b0 || mem_req !== 1'b0) begin
                n_errors++;
                $display("FAIL refill_done %h: rdy=%b data=%h busy=%b mreq=%b want 1 %h 0 0",
                         addr, cpu_ready, cpu_rdata, busy, mem_req, memw(addr));
            end
        end else begin
            if ({cpu_ready, busy, valid_wen, mem_req} !== 4'b0110 ||
                blkidx !== 4'd0) begin
                n_errors++;
                $display("FAIL flush_after_refill: rdy/busy/vw/mreq=%b idx=%0d want 0110 0",
                         {cpu_ready, busy, valid_wen, mem_req}, blkidx);
            end
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h40;
            flush = 1'b1; mem_ack = 1'b1;
            #1;
            n_checks++;
            if ({cpu_ready, mem_req, busy, valid_wen, tag_wen, data_wen}
                !== 6'b0) begin
                n_errors++;
                $display("FAIL reset_outputs: got %b want 000000",
                         {cpu_ready, mem_req, busy, valid_wen,
                          tag_wen, data_wen});
            end
        end
        @(negedge clk);
        rst = 1'b0; cpu_req = 1'b0; flush = 1'b0; mem_ack = 1'b0;
        #1;
        n_checks++;
        if ({busy, mem_req, valid_wen} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_state: busy/mreq/vw=%b want 000",
                     {busy, mem_req, valid_wen});
        end
    endtask

    task automatic test_miss;
        do_miss(32'h0000_0040, 1'b0);
    endtask

    task automatic test_hit;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 32'h0000_0048;
        #1;
        n_checks++;
        if (cpu_ready !== 1'b1 || cpu_rdata !== memw(32'h48) ||
            mem_req !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL hit_48: rdy=%b data=%h mreq=%b busy=%b want 1 %h 0 0",
                     cpu_ready, cpu_rdata, mem_req, busy, memw(32'h48));
        end
        @(negedge clk);
        cpu_req = 1'b0; cpu_addr = 32'h0000_0044;
        #1;
        n_checks++;
        if (cpu_ready !== 1'b0 || mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL no_req: rdy=%b mreq=%b want 0 0",
                     cpu_ready, mem_req);
        end
    endtask

    task automatic test_back_to_back;
        for (int k = 3; k >= 0; k--) begin
            @(negedge clk);
            cpu_req = 1'b1; cpu_addr = 32'h40 + 32'(4 * k);
            #1;
            n_checks++;
            if (cpu_ready !== 1'b1 || cpu_rdata !== memw(cpu_addr)) begin
                n_errors++;
                $display("FAIL b2b_hit %h: rdy=%b data=%h want 1 %h",
                         cpu_addr, cpu_ready, cpu_rdata, memw(cpu_addr));
            end
        end
    endtask

    task automatic test_conflict;
        do_miss(32'h0000_0440, 1'b0);
        do_miss(32'h0000_0040, 1'b0);
    endtask

    task automatic test_flush;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 32'h40; flush = 1'b1;
        #1;
        n_checks++;
        if ({cpu_ready, mem_req, busy} !== 3'b000) begin
            n_errors++;
            $display("FAIL flush_prio: rdy/mreq/busy=%b want 000",
                     {cpu_ready, mem_req, busy});
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            flush = 1'b0;
            #1;
            n_checks++;
            if ({busy, valid_wen, valid_wdata, cpu_ready, mem_req}
                !== 5'b11000 || blkidx !== 4'(i)) begin
                n_errors++;
                $display("FAIL flush_cyc%0d: b/vw/vd/rdy/mr=%b idx=%0d want 11000 %0d",
                         i, {busy, valid_wen, valid_wdata, cpu_ready,
                             mem_req}, blkidx, i);
            end
        end
        do_miss(32'h0000_0040, 1'b0);
    endtask

    task automatic test_flush_in_refill;
        do_miss(32'h0000_0080, 1'b1);
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            flush = (i == 5);
            #1;
            n_checks++;
            if ({busy, valid_wen} !== 2'b11 || blkidx !== 4'(i)) begin
                n_errors++;
                $display("FAIL pend_flush%0d: busy/vw=%b idx=%0d want 11 %0d",
                         i, {busy, valid_wen}, blkidx, i);
            end
        end
        @(negedge clk);
        flush = 1'b0; cpu_req = 1'b0;
        #1;
        n_checks++;
        if ({busy, valid_wen, cpu_ready} !== 3'b000) begin
            n_errors++;
            $display("FAIL flush_drop: busy/vw/rdy=%b want 000",
                     {busy, valid_wen, cpu_ready});
        end
    endtask

    task automatic test_reset_mid_refill;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 32'hC0;
        @(negedge clk);
        #1;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'hC0) begin
            n_errors++;
            $display("FAIL rmid_start: mreq=%b addr=%h want 1 000000c0",
                     mem_req, mem_addr);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mem_ack = 1'b1; mem_rdata = memw(32'hC0 + 32'(4 * k));
        end
        @(negedge clk);
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if ({mem_req, tag_wen, valid_wen, data_wen, busy} !== 5'b0) begin
            n_errors++;
            $display("FAIL rmid_rst: mr/tw/vw/dw/busy=%b want 00000",
                     {mem_req, tag_wen, valid_wen, data_wen, busy});
        end
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b0; cpu_req = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, busy, tag_wen, valid_wen, data_wen} !== 5'b0) begin
            n_errors++;
            $display("FAIL rmid_after: mr/busy/tw/vw/dw=%b want 00000",
                     {mem_req, busy, tag_wen, valid_wen, data_wen});
        end
        do_miss(32'h0000_00C4, 1'b0);
    endtask

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; flush = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        test_reset();
        test_miss();
        test_hit();
        test_back_to_back();
        test_conflict();
        test_flush();
        test_flush_in_refill();
        test_reset_mid_refill();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
